// File: rtl/ks_mp_add_ctrl.sv
// Multi-precision add sequencer around a shared combinational adder core; LSB-first chunk stream.
// Optional subtract mode is compiled in with KS_SUB_EN.
module ks_mp_add_ctrl #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         op_sub,
  input  logic         abort,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         busy
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;
  logic            out_cout_q, out_cout_d;
  logic            accept;
  logic            first_chunk;
  logic            last_chunk;
  logic            sub_cur;

  assign first_chunk = (idx_q == '0);
  assign last_chunk  = (idx_q == LastIdx);

`ifdef KS_SUB_EN
  logic sub_q, sub_d;
  // The first chunk sees op_sub directly; later chunks use the latched mode.
  assign sub_cur = first_chunk ? op_sub : sub_q;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign sub_cur       = 1'b0;
`endif

  // Single-entry output register: a new chunk may enter while the old one drains.
  assign in_ready = ena && !abort && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign add_a   = in_a;
  assign add_b   = sub_cur ? ~in_b : in_b;
  assign add_cin = first_chunk ? sub_cur : carry_q;

  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
`ifdef KS_SUB_EN
    sub_d       = sub_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (abort) begin
      idx_d   = '0;
      carry_d = 1'b0;
`ifdef KS_SUB_EN
      sub_d   = 1'b0;
`endif
    end else if (accept) begin
      out_sum_d   = add_sum;
      out_valid_d = 1'b1;
      if (last_chunk) begin
        out_last_d = 1'b1;
        out_cout_d = add_cout;
        carry_d    = 1'b0;
        idx_d      = '0;
`ifdef KS_SUB_EN
        sub_d      = 1'b0;
`endif
      end else begin
        out_last_d = 1'b0;
        carry_d    = add_cout;
        idx_d      = idx_q + IdxW'(1);
`ifdef KS_SUB_EN
        if (first_chunk) begin
          sub_d = op_sub;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
`ifdef KS_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
`ifdef KS_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign busy      = (idx_q != '0);

endmodule
